pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch sequencer for the single-cycle RISC-V teaching CPU. It drives the instruction ROM word address. It also supports free-run, hold, and single-step operation controlled by board switches and buttons. It replaces the ad-hoc ROM address counter in the top level and computes the next PC from the control unit's select and the immediate generator's output.

## Interface
Parameters:
- IM_WORDS, 16, instruction ROM depth in 32-bit words (power of two)
- IM_AW, 4, ROM word-address width, log2(IM_WORDS)
- RESET_PC, 32'h0000_0000, PC value after reset (word aligned)
- WRAP, 1, behaviour when PC runs past the last ROM word: 1 = wrap to RESET_PC, 0 = halt

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  CPU tick (one-clk pulse from the clock divider); PC advances only on ticks
- hold  in  1  freeze request (sw_i[1]); level-sensitive
- step_btn  in  1  single-step button, asynchronous to clk, not debounced beyond 2FF sync
- pc_sel  in  2  next-PC select: 00 PC+4, 01 branch, 10 jal, 11 jalr
- branch_taken  in  1  branch condition from ALU Zero/compare logic
- imm  in  32  sign-extended immediate from EXT
- rs1_val  in  32  RD1 from the register file (jalr base)
- pc_o  out  32  current PC
- pc_plus4_o  out  32  pc_o + 4 (write-back source for jal/jalr)
- im_addr_o  out  IM_AW  ROM word address = pc_o[IM_AW+1:2]
- halted_o  out  1  unit in HALT
- misalign_o  out  1  halt caused by a misaligned target
- instr_count_o  out  16  retired-instruction count, saturating

## Operation
- Target computation:
  - 00: PC+4
  - 01: PC+imm if branch_taken, else PC+4
  - 10: PC+imm
  - 11: (rs1_val+imm) & ~1
- All arithmetic is 32-bit modulo 2^32.
- Misaligned target: target[1:0] != 0 → go to HALT, set misalign_o, and leave the PC unchanged.
- Out-of-range target: target ≥ RESET_PC + 4·IM_WORDS or target < RESET_PC.
  - WRAP=1: PC ← RESET_PC.
  - WRAP=0: go to HALT, misalign_o stays 0, PC unchanged.
- States: RUN, HOLD, STEP, HALT. Reset state is RUN.
  - RUN: each en advances the PC. hold=1 → HOLD. If hold and en arrive in the same cycle, hold wins and there is no advance.
  - HOLD: en is ignored. A step edge → STEP. hold=0 → RUN. If a step edge and hold=0 arrive in the same cycle, go to RUN and drop the step.
  - STEP: the next en performs exactly one advance, then return to HOLD, or to RUN if hold=0 by then. Further step edges while in STEP are ignored.
  - HALT: sticky. Only rstn exits. en, hold, and step are ignored.
- instr_count_o increments on every advance, including wrap advances. It saturates at 16'hFFFF. It does not increment on a halting attempt.
- Step edges seen while in RUN or HALT are discarded and never queued.

## Timing
- pc_o, instr_count_o, and the state update on the rising clk edge where the condition holds. The new PC is visible the same cycle after that edge.
- im_addr_o and pc_plus4_o are combinational from pc_o, so zero added latency.
- step_btn path: 2FF synchronizer followed by a rising-edge detect. The step edge is seen 2–3 clk after the button rises.
- Reset values:
  - pc_o = RESET_PC
  - pc_plus4_o = RESET_PC+4
  - im_addr_o = RESET_PC[IM_AW+1:2]
  - halted_o = 0, misalign_o = 0, instr_count_o = 0
  - state RUN, synchronizer flops 0
- Reset asserted mid-STEP or in HALT clears everything to the reset values immediately (asynchronous).
- halted_o and misalign_o are registered and assert in the same edge that enters HALT.

## Structure
- Shared package cpu_pkg:
  - PC_SEL_* encodings (00/01/10/11), shared with Ctrl
  - fetch state enum (RUN/HOLD/STEP/HALT)
- One sub-module: step_sync, containing the 2FF synchronizer and rising-edge pulse generator, with 1-clk pulse output.
- Next-PC adder, range check, and FSM live in pc_fetch_unit.

## Test plan
- Free-run, WRAP=1, IM_WORDS=16, pc_sel=00, en every 4 clk → pc_o 0x00,0x04,…,0x3C,0x00. im_addr_o 0..15,0. instr_count_o=16 after 16 ticks.
- WRAP=0, same stimulus → at pc_o=0x3C the next en sets halted_o=1, misalign_o=0. pc_o stays 0x3C and count stays 15. 5 further ticks cause no change.
- Branch: pc=0x10, pc_sel=01, imm=32'hFFFF_FFF8, branch_taken=1 → pc 0x08. Repeat with branch_taken=0 → pc 0x0C (from 0x08).
- jalr: pc_sel=11, rs1_val=0x21, imm=2 → target 0x22 is misaligned → halted_o=1, misalign_o=1, pc unchanged. pc_sel=10 with imm=4 from a fresh reset → pc 0x04.
- hold=1 for 3 ticks → pc unchanged. One step_btn pulse → exactly one advance on the next en. A second pulse before that tick is ignored. hold and en in the same cycle → no advance.
- rstn pulsed low while in STEP with count=5 → pc_o=RESET_PC, count=0, state RUN, pending step lost. The next en advances to 0x04.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions: next-PC select encodings (also used by the control
// unit), the fetch sequencer state enum, and the saturating counter helper.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEL_PLUS4  = 2'b00,
    PC_SEL_BRANCH = 2'b01,
    PC_SEL_JAL    = 2'b10,
    PC_SEL_JALR   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    FETCH_RUN  = 2'b00,
    FETCH_HOLD = 2'b01,
    FETCH_STEP = 2'b10,
    FETCH_HALT = 2'b11
  } fetch_state_e;

  localparam logic [15:0] INSTR_COUNT_MAX = 16'hFFFF;

  // Retired-instruction counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == INSTR_COUNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_if
// Bus between the fetch sequencer and the rest of the single-cycle datapath.
//   pc_sel       [1:0]   next-PC select from control
//   branch_taken         branch condition from ALU compare
//   imm          [31:0]  sign-extended immediate
//   rs1_val      [31:0]  register-file RD1 (jalr base)
//   pc_o         [31:0]  current PC
//   pc_plus4_o   [31:0]  PC + 4 (jal/jalr write-back)
//   im_addr_o    [IM_AW-1:0] instruction ROM word address
// master: datapath/control side, slave: fetch unit side.
// -----------------------------------------------------------------------------
interface pc_fetch_if #(
  parameter int IM_AW = 4
);
  logic [1:0]       pc_sel;
  logic             branch_taken;
  logic [31:0]      imm;
  logic [31:0]      rs1_val;
  logic [31:0]      pc_o;
  logic [31:0]      pc_plus4_o;
  logic [IM_AW-1:0] im_addr_o;

  modport master (
    output pc_sel, branch_taken, imm, rs1_val,
    input  pc_o, pc_plus4_o, im_addr_o
  );

  modport slave (
    input  pc_sel, branch_taken, imm, rs1_val,
    output pc_o, pc_plus4_o, im_addr_o
  );
endinterface

// File: rtl/pc_fetch_unit_step_sync.sv
// -----------------------------------------------------------------------------
// step_sync
// Brings the raw single-step button into the clk domain with a 2FF
// synchronizer and emits a one-clk pulse on each rising edge.
//   clk      in   system clock
//   rstn     in   asynchronous active-low reset
//   i_btn    in   raw button level (asynchronous)
//   o_pulse  out  one-clk pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module step_sync (
  input  logic clk,
  input  logic rstn,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Program counter and instruction-fetch sequencer. Computes the next PC from
// the control select and immediate, checks alignment and ROM range, and runs
// a RUN/HOLD/STEP/HALT sequencer for free-run, freeze and single-step use.
//   clk            in   system clock
//   rstn           in   asynchronous active-low reset
//   en             in   CPU tick; the PC only moves on ticks
//   hold           in   freeze request (level)
//   step_btn       in   single-step button (raw, asynchronous)
//   bus            slave pc_fetch_if: select/imm/rs1 in, pc/pc+4/rom addr out
//   halted_o       out  sequencer is in HALT
//   misalign_o     out  HALT was caused by a misaligned target
//   instr_count_o  out  retired-instruction count, saturating
// -----------------------------------------------------------------------------
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          IM_WORDS = 16,
  parameter int          IM_AW    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WRAP     = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         hold,
  input  logic         step_btn,
  pc_fetch_if.slave    bus,
  output logic         halted_o,
  output logic         misalign_o,
  output logic [15:0]  instr_count_o
);

  // One past the last ROM byte address; 33 bits so the top of the 4 GiB
  // space cannot wrap the comparison.
  localparam logic [32:0] RANGE_END = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [15:0]  r_count;
  logic         r_halted;
  logic         r_misalign;

  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_pc_imm;
  logic [31:0]  w_jalr_sum;
  logic [31:0]  w_target;
  logic         w_misaligned;
  logic         w_out_of_range;
  logic         w_attempt;
  logic         w_step_pulse;
  logic [31:0]  w_pc_nxt;
  logic [15:0]  w_count_nxt;
  logic         w_misalign_nxt;
  logic         w_halted_nxt;

  step_sync u_step_sync (
    .clk     (clk),
    .rstn    (rstn),
    .i_btn   (step_btn),
    .o_pulse (w_step_pulse)
  );

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_imm   = r_pc + bus.imm;
  assign w_jalr_sum = bus.rs1_val + bus.imm;

  always_comb begin
    w_target = w_pc_plus4;
    case (pc_sel_e'(bus.pc_sel))
      PC_SEL_PLUS4:  w_target = w_pc_plus4;
      PC_SEL_BRANCH: w_target = bus.branch_taken ? w_pc_imm : w_pc_plus4;
      PC_SEL_JAL:    w_target = w_pc_imm;
      PC_SEL_JALR:   w_target = w_jalr_sum & ~32'd1;
      default:       w_target = w_pc_plus4;
    endcase
  end

  // jalr clears bit 0 only, so bit 1 can still leave a misaligned target.
  assign w_misaligned   = |w_target[1:0];
  assign w_out_of_range = (w_target < RESET_PC) || ({1'b0, w_target} >= RANGE_END);

  // State register plus the architectural registers it sequences.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= FETCH_RUN;
      r_pc       <= RESET_PC;
      r_count    <= 16'd0;
      r_halted   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_count    <= w_count_nxt;
      r_halted   <= w_halted_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  // Next-state logic. Hold has priority over a same-cycle tick in RUN, and
  // dropping hold in HOLD discards any same-cycle step edge.
  always_comb begin
    w_state_nxt = r_state;
    w_attempt   = 1'b0;
    case (r_state)
      FETCH_RUN: begin
        if (hold) begin
          w_state_nxt = FETCH_HOLD;
        end else if (en) begin
          w_attempt = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (!hold) begin
          w_state_nxt = FETCH_RUN;
        end else if (w_step_pulse) begin
          w_state_nxt = FETCH_STEP;
        end
      end
      FETCH_STEP: begin
        if (en) begin
          w_attempt   = 1'b1;
          w_state_nxt = hold ? FETCH_HOLD : FETCH_RUN;
        end
      end
      FETCH_HALT: w_state_nxt = FETCH_HALT;
      default:    w_state_nxt = FETCH_RUN;
    endcase
    if (w_attempt && (w_misaligned || (w_out_of_range && (WRAP == 0)))) begin
      w_state_nxt = FETCH_HALT;
    end
  end

  // Output/datapath logic: what an advance attempt does to PC, count, flags.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_count_nxt    = r_count;
    w_misalign_nxt = r_misalign;
    if (w_attempt) begin
      if (w_misaligned) begin
        w_misalign_nxt = 1'b1;
      end else if (w_out_of_range) begin
        if (WRAP != 0) begin
          w_pc_nxt    = RESET_PC;
          w_count_nxt = sat_inc16(r_count);
        end
      end else begin
        w_pc_nxt    = w_target;
        w_count_nxt = sat_inc16(r_count);
      end
    end
    w_halted_nxt = (w_state_nxt == FETCH_HALT);
  end

  assign bus.pc_o       = r_pc;
  assign bus.pc_plus4_o = w_pc_plus4;
  assign bus.im_addr_o  = r_pc[IM_AW+1:2];
  assign halted_o       = r_halted;
  assign misalign_o     = r_misalign;
  assign instr_count_o  = r_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed bench for pc_fetch_unit. Two instances share all stimulus: one
// with WRAP=1 and one with WRAP=0, both IM_WORDS=16, RESET_PC=0.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        clk;
  logic        rstn;
  logic        en;
  logic        hold;
  logic        step_btn;
  logic [1:0]  pc_sel;
  logic        branch_taken;
  logic [31:0] imm;
  logic [31:0] rs1_val;

  logic        w_halted_w, w_misalign_w;
  logic [15:0] w_count_w;
  logic        w_halted_n, w_misalign_n;
  logic [15:0] w_count_n;

  int n_chk;
  int n_err;

  pc_fetch_if #(.IM_AW(4)) u_if_w ();
  pc_fetch_if #(.IM_AW(4)) u_if_n ();

  assign u_if_w.pc_sel       = pc_sel;
  assign u_if_w.branch_taken = branch_taken;
  assign u_if_w.imm          = imm;
  assign u_if_w.rs1_val      = rs1_val;
  assign u_if_n.pc_sel       = pc_sel;
  assign u_if_n.branch_taken = branch_taken;
  assign u_if_n.imm          = imm;
  assign u_if_n.rs1_val      = rs1_val;

  pc_fetch_unit #(.IM_WORDS(16), .IM_AW(4), .RESET_PC(32'h0), .WRAP(1)) u_dut_w (
    .clk           (clk),
    .rstn          (rstn),
    .en            (en),
    .hold          (hold),
    .step_btn      (step_btn),
    .bus           (u_if_w.slave),
    .halted_o      (w_halted_w),
    .misalign_o    (w_misalign_w),
    .instr_count_o (w_count_w)
  );

  pc_fetch_unit #(.IM_WORDS(16), .IM_AW(4), .RESET_PC(32'h0), .WRAP(0)) u_dut_n (
    .clk           (clk),
    .rstn          (rstn),
    .en            (en),
    .hold          (hold),
    .step_btn      (step_btn),
    .bus           (u_if_n.slave),
    .halted_o      (w_halted_n),
    .misalign_o    (w_misalign_n),
    .instr_count_o (w_count_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One en pulse, then idle so ticks land every 4 clk.
  task automatic do_tick();
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn         = 1'b0;
    en           = 1'b0;
    hold         = 1'b0;
    step_btn     = 1'b0;
    pc_sel       = 2'b00;
    branch_taken = 1'b0;
    imm          = 32'd0;
    rs1_val      = 32'd0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic press_step();
    @(negedge clk);
    step_btn = 1'b1;
    repeat (2) @(negedge clk);
    step_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_chk        = 0;
    n_err        = 0;
    rstn         = 1'b0;
    en           = 1'b0;
    hold         = 1'b0;
    step_btn     = 1'b0;
    pc_sel       = 2'b00;
    branch_taken = 1'b0;
    imm          = 32'd0;
    rs1_val      = 32'd0;
    repeat (2) @(negedge clk);

    // Reset values while rstn is held low
    check("rst_pc",       u_if_w.pc_o, 32'h0);
    check("rst_pc4",      u_if_w.pc_plus4_o, 32'h4);
    check("rst_imaddr",   {28'd0, u_if_w.im_addr_o}, 32'h0);
    check("rst_halted",   {31'd0, w_halted_w}, 32'h0);
    check("rst_misalign", {31'd0, w_misalign_w}, 32'h0);
    check("rst_count",    {16'd0, w_count_w}, 32'h0);
    check("rst_pc_nw",    u_if_n.pc_o, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Free run over the whole ROM: WRAP=1 wraps, WRAP=0 halts at 0x3C
    for (int k = 1; k <= 16; k++) begin
      do_tick();
      check("run_pc_w",     u_if_w.pc_o, (k == 16) ? 32'h0 : 32'(4 * k));
      check("run_imaddr_w", {28'd0, u_if_w.im_addr_o}, (k == 16) ? 32'h0 : 32'(k));
      check("run_pc_nw",    u_if_n.pc_o, (k == 16) ? 32'h3C : 32'(4 * k));
    end
    check("wrap_count_w",   {16'd0, w_count_w}, 32'd16);
    check("wrap_halted_w",  {31'd0, w_halted_w}, 32'h0);
    check("nw_halted",      {31'd0, w_halted_n}, 32'h1);
    check("nw_misalign",    {31'd0, w_misalign_n}, 32'h0);
    check("nw_count",       {16'd0, w_count_n}, 32'd15);
    for (int k = 0; k < 5; k++) begin
      do_tick();
      check("nw_sticky_pc",    u_if_n.pc_o, 32'h3C);
      check("nw_sticky_count", {16'd0, w_count_n}, 32'd15);
    end
    check("w_after_pc",    u_if_w.pc_o, 32'h14);
    check("w_after_count", {16'd0, w_count_w}, 32'd21);

    // Branch taken backwards, then not taken
    do_reset();
    repeat (4) do_tick();
    check("br_start_pc", u_if_w.pc_o, 32'h10);
    pc_sel       = 2'b01;
    imm          = 32'hFFFF_FFF8;
    branch_taken = 1'b1;
    do_tick();
    check("br_taken_pc", u_if_w.pc_o, 32'h08);
    branch_taken = 1'b0;
    do_tick();
    check("br_not_pc",    u_if_w.pc_o, 32'h0C);
    check("br_pc4",       u_if_w.pc_plus4_o, 32'h10);
    check("br_imaddr",    {28'd0, u_if_w.im_addr_o}, 32'h3);
    check("br_count",     {16'd0, w_count_w}, 32'd6);

    // jalr to 0x22 is misaligned -> HALT with misalign flag, PC kept
    pc_sel  = 2'b11;
    rs1_val = 32'h21;
    imm     = 32'd2;
    do_tick();
    check("jalr_pc",       u_if_w.pc_o, 32'h0C);
    check("jalr_halted",   {31'd0, w_halted_w}, 32'h1);
    check("jalr_misalign", {31'd0, w_misalign_w}, 32'h1);
    check("jalr_count",    {16'd0, w_count_w}, 32'd6);
    pc_sel = 2'b00;
    do_tick();
    check("halt_sticky_pc", u_if_w.pc_o, 32'h0C);

    // jal from a fresh reset
    do_reset();
    check("clr_halted",   {31'd0, w_halted_w}, 32'h0);
    check("clr_misalign", {31'd0, w_misalign_w}, 32'h0);
    pc_sel = 2'b10;
    imm    = 32'd4;
    do_tick();
    check("jal_pc",    u_if_w.pc_o, 32'h04);
    check("jal_count", {16'd0, w_count_w}, 32'd1);

    // hold and en together: hold wins
    do_reset();
    @(negedge clk);
    hold = 1'b1;
    en   = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("hold_en_pc", u_if_w.pc_o, 32'h0);
    repeat (2) do_tick();
    check("hold_pc",    u_if_w.pc_o, 32'h0);
    check("hold_count", {16'd0, w_count_w}, 32'd0);
    // Two presses before the tick still give one advance
    press_step();
    press_step();
    check("step_wait_pc", u_if_w.pc_o, 32'h0);
    do_tick();
    check("step_pc",    u_if_w.pc_o, 32'h04);
    check("step_count", {16'd0, w_count_w}, 32'd1);
    do_tick();
    check("step_once_pc", u_if_w.pc_o, 32'h04);
    hold = 1'b0;
    repeat (2) @(negedge clk);
    do_tick();
    check("resume_pc", u_if_w.pc_o, 32'h08);

    // Asynchronous reset while in STEP with count=5
    do_reset();
    repeat (5) do_tick();
    check("pre_step_count", {16'd0, w_count_w}, 32'd5);
    check("pre_step_pc",    u_if_w.pc_o, 32'h14);
    hold = 1'b1;
    repeat (2) @(negedge clk);
    press_step();
    #2;
    rstn = 1'b0;
    #1;
    check("areset_pc",     u_if_w.pc_o, 32'h0);
    check("areset_count",  {16'd0, w_count_w}, 32'd0);
    check("areset_halted", {31'd0, w_halted_w}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    hold = 1'b0;
    @(negedge clk);
    do_tick();
    check("post_reset_pc",    u_if_w.pc_o, 32'h04);
    check("post_reset_count", {16'd0, w_count_w}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
